// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the write-back stage.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result queue: storage, wrapping pointers and occupancy count.
// Under WB_FORWARD_EN it also exposes every slot in age order (index 0 = oldest).
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] count_o
`ifdef WB_FORWARD_EN
  ,
  output wb_entry_t        slot_o     [DEPTH],
  output logic [DEPTH-1:0] slot_vld_o
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Guards keep count inside 0..DEPTH even if a caller misbehaves.
  assign push_ok = push_i && (count_q < DEPTH_C);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign ready_o = (count_q < DEPTH_C);
  assign count_o = count_q;

`ifdef WB_FORWARD_EN
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_o[k]     = mem_q[rd_ptr_q + PTR_W'(k)];
      slot_vld_o[k] = (CNT_W'(k) < count_q);
    end
  end
`endif

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: filters non-writing results, queues the rest and drains one per cycle
// into a registered register-file write port. Define WB_FORWARD_EN to add rs/rt bypass.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered count, never on in_valid.
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_we,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    CNTRL_RS,
  output logic [REG_ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]       ALU_WB,
  input  logic [REG_ADDR_W-1:0]   rs,
  input  logic [REG_ADDR_W-1:0]   rt,
`ifdef WB_FORWARD_EN
  output logic                    fwd_rs_hit,
  output logic                    fwd_rt_hit,
  output logic [DATA_W-1:0]       fwd_rs_data,
  output logic [DATA_W-1:0]       fwd_rt_data,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  wb_entry_t head;
  wb_entry_t push_entry;
  logic      push, pop;
  wb_entry_t out_q, out_d;
  logic      wen_q, wen_d;

`ifdef WB_FORWARD_EN
  wb_entry_t        slot [DEPTH];
  logic [DEPTH-1:0] slot_vld;
`endif

  // Writes to r0 or without a write enable never occupy a queue slot.
  assign push       = in_valid && in_ready && in_we && (in_rd != '0);
  assign pop        = (count != '0);
  assign push_entry = '{rd: in_rd, data: in_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .ready_o      (in_ready),
    .count_o      (count)
`ifdef WB_FORWARD_EN
    ,
    .slot_o       (slot),
    .slot_vld_o   (slot_vld)
`endif
  );

  always_comb begin
    wen_d = 1'b0;
    out_d = '0;
    if (pop) begin
      wen_d = 1'b1;
      out_d = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= 1'b0;
      out_q <= '0;
    end else begin
      wen_q <= wen_d;
      out_q <= out_d;
    end
  end

  assign CNTRL_RS = wen_q;
  assign rd       = out_q.rd;
  assign ALU_WB   = out_q.data;

`ifdef WB_FORWARD_EN
  // Output register is the oldest candidate; later (younger) queue slots override it.
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = '0;
    if (rs != '0) begin
      if (wen_q && (out_q.rd == rs)) begin
        fwd_rs_hit  = 1'b1;
        fwd_rs_data = out_q.data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_vld[k] && (slot[k].rd == rs)) begin
          fwd_rs_hit  = 1'b1;
          fwd_rs_data = slot[k].data;
        end
      end
    end
    if (rt != '0) begin
      if (wen_q && (out_q.rd == rt)) begin
        fwd_rt_hit  = 1'b1;
        fwd_rt_data = out_q.data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_vld[k] && (slot[k].rd == rt)) begin
          fwd_rt_hit  = 1'b1;
          fwd_rt_data = slot[k].data;
        end
      end
    end
  end
`else
  logic unused_operands;
  assign unused_operands = ^{rs, rt};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_writeback_stage;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_we;
  logic [4:0]    in_rd;
  logic [31:0]   in_data;
  logic          CNTRL_RS;
  logic [4:0]    rd;
  logic [31:0]   ALU_WB;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [CW-1:0] count;
`ifdef WB_FORWARD_EN
  logic          fwd_rs_hit, fwd_rt_hit;
  logic [31:0]   fwd_rs_data, fwd_rt_data;
`endif

  writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_we       (in_we),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .CNTRL_RS    (CNTRL_RS),
    .rd          (rd),
    .ALU_WB      (ALU_WB),
    .rs          (rs),
    .rt          (rt),
`ifdef WB_FORWARD_EN
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data),
`endif
    .count       (count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // exp_q holds {rd, data} of queued writes, oldest at the front.
  logic [36:0] exp_q[$];
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wen  = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  // One clock: model samples the handshake before the edge, outputs are checked 1ns after.
  task automatic step();
    logic        acc;
    logic [36:0] e;
    acc = in_valid && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      m_wen  = 1'b1;
      m_rd   = e[36:32];
      m_data = e[31:0];
    end else begin
      m_wen  = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end
    if (acc && in_we && (in_rd != 5'd0)) exp_q.push_back({in_rd, in_data});
    #1;
  endtask

`ifdef WB_FORWARD_EN
  task automatic fwd_model(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (!hit && exp_q[i][36:32] == a) begin
          hit = 1'b1;
          d   = exp_q[i][31:0];
        end
      end
      if (!hit && m_wen && m_rd == a) begin
        hit = 1'b1;
        d   = m_data;
      end
    end
  endtask
`endif

  task automatic compare_model(input string tag);
`ifdef WB_FORWARD_EN
    logic        h;
    logic [31:0] d;
`endif
    check({tag, ".CNTRL_RS"}, 32'(CNTRL_RS), 32'(m_wen));
    check({tag, ".rd"},       32'(rd),       32'(m_rd));
    check({tag, ".ALU_WB"},   ALU_WB,        m_data);
    check({tag, ".count"},    32'(count),    32'(exp_q.size()));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_q.size() < DEPTH));
`ifdef WB_FORWARD_EN
    fwd_model(rs, h, d);
    check({tag, ".fwd_rs_hit"},  32'(fwd_rs_hit), 32'(h));
    check({tag, ".fwd_rs_data"}, fwd_rs_data,     d);
    fwd_model(rt, h, d);
    check({tag, ".fwd_rt_hit"},  32'(fwd_rt_hit), 32'(h));
    check({tag, ".fwd_rt_data"}, fwd_rt_data,     d);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic we, input logic [4:0] r, input logic [31:0] d);
    in_valid = v;
    in_we    = we;
    in_rd    = r;
    in_data  = d;
  endtask

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
    logic        exp_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Table: single-entry latency, filtered writes, back-to-back pair.
    vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h55,       1'b0, 5'd0,  32'h0,        1};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h55,       0};
    vecs[2] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        0};
    vecs[3] = '{1'b1, 1'b1, 5'd0,  32'hFF,       1'b0, 5'd0,  32'h0,        0};
    vecs[4] = '{1'b1, 1'b0, 5'd7,  32'h77,       1'b0, 5'd0,  32'h0,        0};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        0};
    vecs[6] = '{1'b1, 1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1};
    vecs[7] = '{1'b1, 1'b1, 5'd1,  32'h1,        1'b1, 5'd31, 32'hDEADBEEF, 1};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'h1,        0};
    vecs[9] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    rs = 5'd0;
    rt = 5'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.CNTRL_RS", 32'(CNTRL_RS), 32'd0);
    check("reset.rd",       32'(rd),       32'd0);
    check("reset.ALU_WB",   ALU_WB,        32'd0);
    check("reset.count",    32'(count),    32'd0);
    rst_n = 1'b1;
    step();
    check("reset.in_ready", 32'(in_ready), 32'd1);

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].r, vecs[i].d);
      step();
      check($sformatf("vec%0d.CNTRL_RS", i), 32'(CNTRL_RS), 32'(vecs[i].exp_wen));
      check($sformatf("vec%0d.rd", i),       32'(rd),       32'(vecs[i].exp_rd));
      check($sformatf("vec%0d.ALU_WB", i),   ALU_WB,        vecs[i].exp_data);
      check($sformatf("vec%0d.count", i),    32'(count),    32'(vecs[i].exp_count));
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      compare_model($sformatf("vec%0d.model", i));
    end

    // ---- sustained stream of six results ----
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'd9, 32'(i + 1));
      step();
      check("stream.count_max", 32'(count <= CW'(DEPTH)), 32'd1);
      if (i >= 1) begin
        check("stream.CNTRL_RS", 32'(CNTRL_RS), 32'd1);
        check("stream.ALU_WB",   ALU_WB,        32'(i));
      end
      compare_model("stream.model");
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("stream.last", ALU_WB, 32'd6);
    compare_model("stream.tail");
    step();

`ifdef WB_FORWARD_EN
    // ---- bypass: youngest queued entry wins over output register ----
    drive(1'b1, 1'b1, 5'd5, 32'h10);
    step();
    drive(1'b1, 1'b1, 5'd5, 32'h20);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    rs = 5'd5;
    rt = 5'd0;
    #1;
    check("fwd.rs_hit",  32'(fwd_rs_hit), 32'd1);
    check("fwd.rs_data", fwd_rs_data,     32'h20);
    check("fwd.rt_hit",  32'(fwd_rt_hit), 32'd0);
    check("fwd.rt_data", fwd_rt_data,     32'd0);
    step();
    check("fwd.outreg_hit",  32'(fwd_rs_hit), 32'd1);
    check("fwd.outreg_data", fwd_rs_data,     32'h20);
    step();
    check("fwd.drained_hit", 32'(fwd_rs_hit), 32'd0);
    rs = 5'd0;
`endif

    // ---- reset mid-drain ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 32'(32'hA0 + i));
      step();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.CNTRL_RS", 32'(CNTRL_RS), 32'd0);
    check("midrst.count",    32'(count),    32'd0);
    check("midrst.ALU_WB",   ALU_WB,        32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("postrst.CNTRL_RS", 32'(CNTRL_RS), 32'd0);
      compare_model("postrst.model");
    end

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), $urandom);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      step();
      compare_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the result-queue depth; legal values are powers of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream result valid.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_we  input  1  result carries a register write.
REQ-007 in_rd  input  5  destination register of the result.
REQ-008 in_data  input  32  result value.
REQ-009 CNTRL_RS  output  1  register-file write enable.
REQ-010 rd  output  5  register-file write address.
REQ-011 ALU_WB  output  32  register-file write data.
REQ-012 rs, rt  input  5 each  operand addresses being read from the register file this cycle.
REQ-013 fwd_rs_hit, fwd_rt_hit  output  1 each; fwd_rs_data, fwd_rt_data  output  32 each  bypass results (present only under REQ-030).
REQ-014 count  output  clog2(DEPTH)+1  number of queued entries.

Function
REQ-015 A handshake SHALL occur on a rising edge where in_valid && in_ready; at all other edges inputs are ignored.
REQ-016 in_ready SHALL equal (count < DEPTH), with no combinational path from any input.
REQ-017 An accepted result with in_we=0 or in_rd=0 SHALL be discarded and not enqueued.
REQ-018 Other accepted results SHALL be enqueued in FIFO order as {in_rd, in_data}.
REQ-019 On every edge where the queue is non-empty, the head SHALL be popped into the output register: CNTRL_RS=1, rd=head rd, ALU_WB=head data.
REQ-020 On every edge where the queue is empty, the output register SHALL load CNTRL_RS=0, rd=0, ALU_WB=0.
REQ-021 Minimum latency SHALL be one cycle: a result accepted at edge N drives CNTRL_RS at edge N+1 when the queue was empty.
REQ-022 Push and pop in the same edge SHALL both take effect; count is unchanged.
REQ-023 When full, in_ready=0; the pop at that edge frees one slot, so in_ready=1 in the following cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 Throughput SHALL be one write-back per cycle sustained.

Reset
REQ-026 While rst_n=0: count=0, pointers=0, CNTRL_RS=0, rd=0, ALU_WB=0, in_ready=1 from the next cycle after release; queue contents are don't-care.
REQ-027 Reset asserted mid-operation SHALL discard all queued and in-flight results; none are written afterwards.

Configuration
REQ-028 Macro WB_FORWARD_EN SHALL compile the bypass logic in or out.
REQ-029 Without WB_FORWARD_EN: fwd_* ports SHALL be absent; queue behaviour is unchanged.
REQ-030 With WB_FORWARD_EN: fwd_rs_hit=1 SHALL be asserted when rs!=0 and rs matches a queued entry or the output register while CNTRL_RS=1. fwd_rs_data SHALL come from the youngest match, where the youngest queued entry outranks the output register. Signals are combinational; rt behaves identically.
REQ-031 With WB_FORWARD_EN and no match, hit=0 and data=0.

Structure
REQ-032 Package wb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32 and typedef wb_entry_t {rd, data}.
REQ-033 Sub-module wb_fifo SHALL implement storage, pointers and count. writeback_stage holds the output register, filtering and bypass.

Verification
REQ-034 Reset, then push {rd=3, data=0x55} -> next cycle CNTRL_RS=1, rd=3, ALU_WB=0x55. The following cycle CNTRL_RS=0, rd=0, ALU_WB=0.
REQ-035 Push {rd=0, 0xFF}, then {rd=7, we=0} -> count stays 0 and CNTRL_RS never asserts.
REQ-036 DEPTH=4, hold in_valid for 6 cycles with data 1..6 -> writes 1..6 appear in order on consecutive cycles, and count never exceeds 4.
REQ-037 WB_FORWARD_EN with entries {rd=5, 0x10} then {rd=5, 0x20} queued and rs=5 -> fwd_rs_hit=1 and fwd_rs_data=0x20. With rs=0 -> fwd_rs_hit=0.
REQ-038 Queue 3 entries, pulse rst_n=0 mid-drain -> CNTRL_RS=0 immediately, count=0, and no further writes after release.
